branch_unit_bht: RTL and testbench
==================================

Name: branch_unit_bht

Overview:
- Execute-stage branch resolution unit with an integrated branch history table (BHT) of saturating counters.
- Resolves RV32I/RV64I conditional branches and jumps: signed or unsigned compare, selected from funct3 (no external unsigned-select input).
- Drives pcsel combinationally and provides taken/not-taken predictions to fetch.
- Trains the BHT, flags mispredictions and keeps branch/mispredict performance counters.

Parameters:
- XLEN, 32, operand and PC width (32 or 64).
- BHT_ENTRIES, 64, number of predictor entries; power of 2, minimum 2.
- CTR_W, 2, saturating counter width; minimum 1.
- CTR_INIT, 1, reset/flush value of every counter; must be below 2^CTR_W.
- PERF_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pred_pc  in  XLEN  fetch PC to predict
- pred_taken  out  1  prediction for pred_pc (counter MSB)
- ex_valid  in  1  execute-stage instruction valid
- ex_pc  in  XLEN  PC of the execute-stage instruction
- ex_opcode  in  7  instruction opcode
- ex_funct3  in  3  instruction funct3
- ex_rs1  in  XLEN  operand A
- ex_rs2  in  XLEN  operand B
- ex_pred_taken  in  1  prediction fetch made for this instruction
- pcsel  out  1  take branch/jump target this cycle (combinational)
- mispredict  out  1  registered; high 1 cycle after a mispredicted conditional branch
- bht_flush  in  1  synchronous clear of all counters to CTR_INIT
- perf_branches  out  PERF_W  resolved conditional-branch count
- perf_mispredicts  out  PERF_W  mispredicted conditional-branch count

Behaviour:
- Reset (rst_n low, asynchronous): all counters = CTR_INIT; mispredict = 0; perf_branches = 0; perf_mispredicts = 0. pred_taken follows the reset table value.
- Index: IDX_W = log2(BHT_ENTRIES); idx = pc[IDX_W+1:2]. Applies to both pred_pc and ex_pc.
- Prediction: combinational read, pred_taken = counter[idx(pred_pc)][CTR_W-1]. No bypass: a write takes effect on the next cycle.
- Compare: equality is width-agnostic.
  - funct3 100/101: signed less-than.
  - funct3 110/111: unsigned less-than.
- Conditional-branch taken (opcode 1100011):
  - 000 BEQ: eq
  - 001 BNE: !eq
  - 100/110: lt
  - 101/111: !lt
  - 010/011: illegal; taken = 0, and the instruction is not treated as a branch.
- pcsel: ex_valid & (legal branch taken, or opcode 1101111 JAL, or opcode 1100111 JALR). pcsel = 0 when ex_valid = 0.
- Training: on a clock edge with ex_valid and a legal conditional branch:
  - counter[idx(ex_pc)] increments if taken, decrements if not taken.
  - Saturates at 2^CTR_W-1 and at 0.
  - JAL/JALR, illegal funct3 and non-branch instructions never train.
- Mispredict: registered each cycle as ex_valid & legal branch & (taken != ex_pred_taken). It is high for exactly one cycle per event and 0 otherwise. Back-to-back mispredicts give consecutive high cycles.
- Performance counters:
  - perf_branches increments on each training event.
  - perf_mispredicts increments on each mispredict event, in the same cycle the mispredict register is loaded.
  - Both wrap modulo 2^PERF_W and are not cleared by bht_flush.
- bht_flush:
  - On the clock edge, every counter is set to CTR_INIT.
  - A training update in the same cycle is discarded (flush wins).
  - Mispredict and perf counters still update in that cycle.
- A reset asserted mid-stream aborts everything immediately. No pending update survives.

Decomposition:
- Shared package (riscv_pkg): opcode constants OP_BRANCH=1100011, OP_JAL=1101111, OP_JALR=1100111; funct3 constants F3_BEQ/BNE/BLT/BGE/BLTU/BGEU.
- One sub-module, sat_counter (parametrised CTR_W, inc/dec/en/clear), instantiated BHT_ENTRIES times.
- Compare and decode logic stays in the top level.

Test Plan:
- Reset, then BEQ 5,5 with ex_pred_taken=0 → pcsel=1; next cycle mispredict=1, perf_branches=1, perf_mispredicts=1; counter[idx] 1→2, so pred_taken for that pc becomes 1.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken, pcsel=1. BLTU with the same operands → not taken, pcsel=0.
- Saturation: same-pc BNE taken 5 times → counter stops at 3. Then 4 not-taken → counter 0, pred_taken=0.
- Aliasing: pcs 0x100 and 0x200 with BHT_ENTRIES=64 map to the same index → training on 0x100 changes pred_taken for 0x200.
- Jump/illegal/invalid cases:
  - JAL → pcsel=1, no training, no perf increment.
  - funct3=010 on branch opcode → pcsel=0, no training.
  - ex_valid=0 with a taken BEQ → pcsel=0.
- Flush with simultaneous training, then reset mid-stream:
  - bht_flush concurrent with a training branch → all counters read CTR_INIT next cycle, but perf_branches increments.
  - rst_n pulled low mid-stream → mispredict and perf counters go to 0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings used by the execute-stage branch logic.
package riscv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/sat_counter.sv
// Up/down saturating counter with synchronous clear; one BHT entry.
module sat_counter #(
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [CTR_W-1:0] ctr_o
);

  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_RST  = CTR_W'(CTR_INIT);

  logic [CTR_W-1:0] ctr_q, ctr_d;

  // NOTE: ctr_d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    ctr_d = ctr_q;
    if (clear_i) begin
      ctr_d = CTR_RST;
    end else if (en_i) begin
      if (inc_i && ctr_q != CTR_MAX) begin
        ctr_d = ctr_q + CTR_W'(1);
      end else if (!inc_i && ctr_q != '0) begin
        ctr_d = ctr_q - CTR_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q <= CTR_RST;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_unit_bht.sv
// Execute-stage branch resolution with a PC-indexed table of saturating counters.
module branch_unit_bht
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_W       = 2,
  parameter int CTR_INIT    = 1,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pred_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [6:0]        ex_opcode,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic              ex_pred_taken,
  output logic              pcsel,
  output logic              mispredict,
  input  logic              bht_flush,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0] pred_idx, ex_idx;
  logic [CTR_W-1:0] ctr [BHT_ENTRIES];

  logic eq, lt, br_legal, br_taken, is_jump, train, mispredict_d;
  logic mispredict_q;
  logic [PERF_W-1:0] perf_branches_q, perf_branches_d;
  logic [PERF_W-1:0] perf_mispredicts_q, perf_mispredicts_d;

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign ex_idx   = ex_pc[IDX_W+1:2];

  // Word-offset and high PC bits play no part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                            ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  // funct3[1] separates the unsigned compares (BLTU/BGEU) from the signed ones.
  always_comb begin
    eq       = (ex_rs1 == ex_rs2);
    lt       = ex_funct3[1] ? (ex_rs1 < ex_rs2) : ($signed(ex_rs1) < $signed(ex_rs2));
    br_legal = (ex_opcode == OP_BRANCH) && (ex_funct3[2:1] != 2'b01);
    is_jump  = (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR);
    br_taken = 1'b0;
    if (br_legal) begin
      case (ex_funct3)
        F3_BEQ:           br_taken = eq;
        F3_BNE:           br_taken = !eq;
        F3_BLT, F3_BLTU:  br_taken = lt;
        F3_BGE, F3_BGEU:  br_taken = !lt;
        default:          br_taken = 1'b0;
      endcase
    end
  end

  assign pcsel        = ex_valid && (br_taken || is_jump);
  assign train        = ex_valid && br_legal;
  assign mispredict_d = train && (br_taken != ex_pred_taken);

  // NOTE: the table is built from individually reset flops rather than a RAM, so reset and flush can clear every entry at once.
  for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
    sat_counter #(
      .CTR_W    (CTR_W),
      .CTR_INIT (CTR_INIT)
    ) u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (train && !bht_flush && (ex_idx == IDX_W'(i))),
      .inc_i   (br_taken),
      .clear_i (bht_flush),
      .ctr_o   (ctr[i])
    );
  end

  assign pred_taken = ctr[pred_idx][CTR_W-1];

  // Flush only touches the table; statistics keep counting through it.
  always_comb begin
    perf_branches_d    = perf_branches_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (train)        perf_branches_d    = perf_branches_q + PERF_W'(1);
    if (mispredict_d) perf_mispredicts_d = perf_mispredicts_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_q       <= 1'b0;
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      mispredict_q       <= mispredict_d;
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign mispredict       = mispredict_q;
  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_unit_bht.sv
// Directed-vector bench for branch_unit_bht with default parameters.
module tb_branch_unit_bht;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2;
  logic        ex_pred_taken;
  logic        pcsel;
  logic        mispredict;
  logic        bht_flush;
  logic [31:0] perf_branches, perf_mispredicts;

  int n_vec = 0;
  int n_err = 0;
  int exp_br = 0;
  int exp_mp = 0;

  branch_unit_bht dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_opcode        (ex_opcode),
    .ex_funct3        (ex_funct3),
    .ex_rs1           (ex_rs1),
    .ex_rs2           (ex_rs2),
    .ex_pred_taken    (ex_pred_taken),
    .pcsel            (pcsel),
    .mispredict       (mispredict),
    .bht_flush        (bht_flush),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic pt);
    ex_valid = 1'b1; ex_pc = pc; ex_opcode = op; ex_funct3 = f3;
    ex_rs1 = a; ex_rs2 = b; ex_pred_taken = pt;
    #1;
  endtask

  task automatic peek(input logic [31:0] pc);
    pred_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bht_flush = 1'b0; pred_pc = '0;
    ex_valid = 1'b0; ex_pc = '0; ex_opcode = '0; ex_funct3 = '0;
    ex_rs1 = '0; ex_rs2 = '0; ex_pred_taken = 1'b0;
    #12;
    n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL reset_mispredict got %b want 0", mispredict); end
    n_vec++; if (perf_branches !== 32'd0) begin n_err++; $display("FAIL reset_perf_br got %0d want 0", perf_branches); end
    n_vec++; if (perf_mispredicts !== 32'd0) begin n_err++; $display("FAIL reset_perf_mp got %0d want 0", perf_mispredicts); end
    peek(32'h40);
    n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred got %b want 0", pred_taken); end
    #9 rst_n = 1'b1;
    step();
  endtask

  task automatic test_beq_mispredict();
    drive(32'h40, OP_BRANCH, F3_BEQ, 32'd5, 32'd5, 1'b0);
    n_vec++; if (pcsel !== 1'b1) begin n_err++; $display("FAIL beq_pcsel got %b want 1", pcsel); end
    step(); idle(); exp_br++; exp_mp++;
    n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL beq_mispredict got %b want 1", mispredict); end
    n_vec++; if (perf_branches !== 32'(exp_br)) begin n_err++; $display("FAIL beq_perf_br got %0d want %0d", perf_branches, exp_br); end
    n_vec++; if (perf_mispredicts !== 32'(exp_mp)) begin n_err++; $display("FAIL beq_perf_mp got %0d want %0d", perf_mispredicts, exp_mp); end
    peek(32'h40);
    n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL beq_pred got %b want 1", pred_taken); end
    step();
    n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL beq_mp_pulse got %b want 0", mispredict); end
  endtask

  task automatic test_compare();
    drive(32'h80, OP_BRANCH, F3_BLT, 32'hFFFF_FFFF, 32'd1, 1'b1);
    n_vec++; if (pcsel !== 1'b1) begin n_err++; $display("FAIL blt_pcsel got %b want 1", pcsel); end
    step(); exp_br++;
    n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL blt_mispredict got %b want 0", mispredict); end
    drive(32'h80, OP_BRANCH, F3_BLTU, 32'hFFFF_FFFF, 32'd1, 1'b1);
    n_vec++; if (pcsel !== 1'b0) begin n_err++; $display("FAIL bltu_pcsel got %b want 0", pcsel); end
    step(); idle(); exp_br++; exp_mp++;
    n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL bltu_mispredict got %b want 1", mispredict); end
    drive(32'h80, OP_BRANCH, F3_BGE, 32'hFFFF_FFFF, 32'd1, 1'b0);
    n_vec++; if (pcsel !== 1'b0) begin n_err++; $display("FAIL bge_pcsel got %b want 0", pcsel); end
    drive(32'h80, OP_BRANCH, F3_BGEU, 32'hFFFF_FFFF, 32'd1, 1'b0);
    n_vec++; if (pcsel !== 1'b1) begin n_err++; $display("FAIL bgeu_pcsel got %b want 1", pcsel); end
    idle();
    n_vec++; if (perf_branches !== 32'(exp_br)) begin n_err++; $display("FAIL cmp_perf_br got %0d want %0d", perf_branches, exp_br); end
  endtask

  task automatic test_saturation();
    logic exp_nt [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(32'hC0, OP_BRANCH, F3_BNE, 32'd1, 32'd2, 1'b1);
      n_vec++; if (pcsel !== 1'b1) begin n_err++; $display("FAIL sat_t_pcsel[%0d] got %b want 1", i, pcsel); end
      step(); idle(); exp_br++;
      n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL sat_t_mp[%0d] got %b want 0", i, mispredict); end
    end
    peek(32'hC0);
    n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL sat_high_pred got %b want 1", pred_taken); end
    for (int i = 0; i < 5; i++) begin
      drive(32'hC0, OP_BRANCH, F3_BNE, 32'd3, 32'd3, 1'b0);
      step(); idle(); exp_br++;
      peek(32'hC0);
      n_vec++; if (pred_taken !== exp_nt[i]) begin n_err++; $display("FAIL sat_nt_pred[%0d] got %b want %b", i, pred_taken, exp_nt[i]); end
    end
    drive(32'hC0, OP_BRANCH, F3_BNE, 32'd1, 32'd2, 1'b1);
    step(); idle(); exp_br++;
    peek(32'hC0);
    n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL sat_low_up1 got %b want 0", pred_taken); end
    drive(32'hC0, OP_BRANCH, F3_BNE, 32'd1, 32'd2, 1'b1);
    step(); idle(); exp_br++;
    peek(32'hC0);
    n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL sat_low_up2 got %b want 1", pred_taken); end
    n_vec++; if (perf_branches !== 32'(exp_br)) begin n_err++; $display("FAIL sat_perf_br got %0d want %0d", perf_branches, exp_br); end
    n_vec++; if (perf_mispredicts !== 32'(exp_mp)) begin n_err++; $display("FAIL sat_perf_mp got %0d want %0d", perf_mispredicts, exp_mp); end
  endtask

  task automatic test_aliasing();
    peek(32'h200);
    n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_before got %b want 0", pred_taken); end
    drive(32'h100, OP_BRANCH, F3_BEQ, 32'd9, 32'd9, 1'b1);
    step(); idle(); exp_br++;
    peek(32'h200);
    n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL alias_after got %b want 1", pred_taken); end
    peek(32'h104);
    n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_neighbour got %b want 0", pred_taken); end
  endtask

  task automatic test_jump_illegal();
    drive(32'h144, OP_JAL, 3'b000, 32'd1, 32'd2, 1'b0);
    n_vec++; if (pcsel !== 1'b1) begin n_err++; $display("FAIL jal_pcsel got %b want 1", pcsel); end
    step();
    n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL jal_mp got %b want 0", mispredict); end
    drive(32'h144, OP_JALR, 3'b000, 32'd1, 32'd2, 1'b0);
    n_vec++; if (pcsel !== 1'b1) begin n_err++; $display("FAIL jalr_pcsel got %b want 1", pcsel); end
    step();
    drive(32'h144, OP_BRANCH, 3'b010, 32'd4, 32'd4, 1'b1);
    n_vec++; if (pcsel !== 1'b0) begin n_err++; $display("FAIL illegal_pcsel got %b want 0", pcsel); end
    step();
    n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL illegal_mp got %b want 0", mispredict); end
    drive(32'h144, OP_BRANCH, F3_BEQ, 32'd4, 32'd4, 1'b0);
    ex_valid = 1'b0; #1;
    n_vec++; if (pcsel !== 1'b0) begin n_err++; $display("FAIL invalid_pcsel got %b want 0", pcsel); end
    step();
    n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL invalid_mp got %b want 0", mispredict); end
    n_vec++; if (perf_branches !== 32'(exp_br)) begin n_err++; $display("FAIL jump_perf_br got %0d want %0d", perf_branches, exp_br); end
    peek(32'h144);
    n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL jump_no_train got %b want 0", pred_taken); end
  endtask

  task automatic test_back_to_back();
    drive(32'h3F8, OP_BRANCH, F3_BEQ, 32'd1, 32'd2, 1'b1);
    step(); exp_br++; exp_mp++;
    n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL b2b_first got %b want 1", mispredict); end
    drive(32'h3F8, OP_BRANCH, F3_BNE, 32'd1, 32'd2, 1'b0);
    step(); idle(); exp_br++; exp_mp++;
    n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL b2b_second got %b want 1", mispredict); end
    step();
    n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b want 0", mispredict); end
    n_vec++; if (perf_mispredicts !== 32'(exp_mp)) begin n_err++; $display("FAIL b2b_perf_mp got %0d want %0d", perf_mispredicts, exp_mp); end
  endtask

  task automatic test_flush();
    bht_flush = 1'b1;
    drive(32'h40, OP_BRANCH, F3_BEQ, 32'd7, 32'd7, 1'b0);
    n_vec++; if (pcsel !== 1'b1) begin n_err++; $display("FAIL flush_pcsel got %b want 1", pcsel); end
    step(); idle(); bht_flush = 1'b0; exp_br++; exp_mp++;
    n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL flush_mp got %b want 1", mispredict); end
    n_vec++; if (perf_branches !== 32'(exp_br)) begin n_err++; $display("FAIL flush_perf_br got %0d want %0d", perf_branches, exp_br); end
    n_vec++; if (perf_mispredicts !== 32'(exp_mp)) begin n_err++; $display("FAIL flush_perf_mp got %0d want %0d", perf_mispredicts, exp_mp); end
    peek(32'h40);
    n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL flush_pred_40 got %b want 0", pred_taken); end
    peek(32'h100);
    n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL flush_pred_100 got %b want 0", pred_taken); end
    peek(32'hC0);
    n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL flush_pred_c0 got %b want 0", pred_taken); end
  endtask

  task automatic test_reset_mid();
    drive(32'h100, OP_BRANCH, F3_BEQ, 32'd2, 32'd2, 1'b0);
    step(); exp_br++; exp_mp++;
    n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL rmid_pre_mp got %b want 1", mispredict); end
    pred_pc = 32'h100;
    drive(32'h100, OP_BRANCH, F3_BEQ, 32'd2, 32'd2, 1'b0);
    n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL rmid_pre_pred got %b want 1", pred_taken); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL rmid_mp got %b want 0", mispredict); end
    n_vec++; if (perf_branches !== 32'd0) begin n_err++; $display("FAIL rmid_perf_br got %0d want 0", perf_branches); end
    n_vec++; if (perf_mispredicts !== 32'd0) begin n_err++; $display("FAIL rmid_perf_mp got %0d want 0", perf_mispredicts); end
    n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rmid_pred got %b want 0", pred_taken); end
    step(); idle();
    #2 rst_n = 1'b1;
    step();
    n_vec++; if (perf_branches !== 32'd0) begin n_err++; $display("FAIL rmid_post_br got %0d want 0", perf_branches); end
    n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL rmid_post_mp got %b want 0", mispredict); end
    n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rmid_post_pred got %b want 0", pred_taken); end
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_compare();
    test_saturation();
    test_aliasing();
    test_jump_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
